// File: rtl/spi_flash_rd_seq_pkg.sv
// Shared definitions for the SPI-flash read sequencer and the spi_master register
// port it drives: register map, STATUS bit positions, CTRL layout and FSM states.
package spi_flash_rd_seq_pkg;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_STATUS = 2'd1,
    REG_RDATA  = 2'd2,
    REG_WDATA  = 2'd3
  } spi_reg_e;

  localparam int ST_RX_FULL  = 0;
  localparam int ST_RX_EMPTY = 1;
  localparam int ST_TX_FULL  = 2;
  localparam int ST_TX_EMPTY = 3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_CSN_BIT  = 1;
  localparam int CTRL_CPHA_BIT = 2;
  localparam int CTRL_CPOL_BIT = 3;
  localparam int CTRL_DIV_LSB  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_ON,
    S_STAT,
    S_PUSH,
    S_POP,
    S_CS_OFF,
    S_FIN
  } seq_state_e;

  function automatic logic [31:0] ctrl_word(input logic [15:0] div,
                                            input logic        cpol,
                                            input logic        cpha,
                                            input logic        cs_n,
                                            input logic        en);
    logic [31:0] w;
    w = '0;
    w[CTRL_DIV_LSB +: 16] = div;
    w[CTRL_CPOL_BIT]      = cpol;
    w[CTRL_CPHA_BIT]      = cpha;
    w[CTRL_CSN_BIT]       = cs_n;
    w[CTRL_EN_BIT]        = en;
    return w;
  endfunction

endpackage

// File: rtl/spi_flash_rd_seq.sv
// SPI-flash READ sequencer: drives the spi_master register port to send opcode,
// 24-bit address and dummy bytes, and streams the returned data bytes out.
module spi_flash_rd_seq
  import spi_flash_rd_seq_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter int          LEN_W    = 12,
  parameter logic [15:0] SCK_DIV  = 16'd4,
  parameter logic        CPOL     = 1'b0,
  parameter logic        CPHA     = 1'b0,
  parameter logic [7:0]  RD_CMD   = 8'h03,
  parameter int          INFLIGHT = 4,
  parameter logic [15:0] TIMEOUT  = 16'hFFFF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic [23:0]      addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [7:0]       rdata_o,
  output logic             rvalid_o,
  output logic             spi_stb_o,
  output logic [1:0]       spi_adr_o,
  output logic [3:0]       spi_byte_sel_o,
  output logic             spi_we_o,
  output logic [XLEN-1:0]  spi_dat_o,
  input  logic [XLEN-1:0]  spi_dat_i
);

  localparam int            CW       = LEN_W + 1;
  localparam logic [CW-1:0] INFL     = CW'(INFLIGHT);
  localparam logic [CW-1:0] HDR      = CW'(4);
  localparam logic [15:0]   TMO_LAST = TIMEOUT - 16'd1;

  seq_state_e    state, state_nx;
  logic [23:0]   addr_q;
  logic [CW-1:0] total, tx_cnt, rx_cnt;
  logic [15:0]   tmo_cnt;
  logic          abort;
  logic          tmo_hit;
  logic [7:0]    tx_byte;
  logic          unused_dat;

  assign unused_dat = ^spi_dat_i[XLEN-1:8];

  assign busy_o = (state != S_IDLE);
  assign done_o = (state == S_FIN);
  assign err_o  = (state == S_FIN) && abort;

  // Header bytes first, then zero filler that clocks the data bytes in.
  always_comb begin
    tx_byte = 8'h00;
    if      (tx_cnt == CW'(0)) tx_byte = RD_CMD;
    else if (tx_cnt == CW'(1)) tx_byte = addr_q[23:16];
    else if (tx_cnt == CW'(2)) tx_byte = addr_q[15:8];
    else if (tx_cnt == CW'(3)) tx_byte = addr_q[7:0];
  end

  // NOTE: every output of this block gets a default before the case so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx       = state;
    tmo_hit        = 1'b0;
    spi_stb_o      = 1'b0;
    spi_adr_o      = REG_CTRL;
    spi_byte_sel_o = 4'h0;
    spi_we_o       = 1'b0;
    spi_dat_o      = '0;
    case (state)
      S_IDLE: begin
        if (req_i) state_nx = (len_i == '0) ? S_FIN : S_CS_ON;
      end
      S_CS_ON: begin
        spi_stb_o      = 1'b1;
        spi_adr_o      = REG_CTRL;
        spi_byte_sel_o = 4'hF;
        spi_we_o       = 1'b1;
        spi_dat_o      = XLEN'(ctrl_word(SCK_DIV, CPOL, CPHA, 1'b0, 1'b1));
        state_nx       = S_STAT;
      end
      S_STAT: begin
        spi_stb_o      = 1'b1;
        spi_adr_o      = REG_STATUS;
        spi_byte_sel_o = 4'hF;
        if (rx_cnt == total)
          state_nx = S_CS_OFF;
        else if (!spi_dat_i[ST_RX_EMPTY] && (rx_cnt < tx_cnt))
          state_nx = S_POP;
        else if ((tx_cnt < total) && ((tx_cnt - rx_cnt) < INFL) && !spi_dat_i[ST_TX_FULL])
          state_nx = S_PUSH;
        else if (tmo_cnt == TMO_LAST) begin
          state_nx = S_CS_OFF;
          tmo_hit  = 1'b1;
        end
      end
      S_PUSH: begin
        spi_stb_o      = 1'b1;
        spi_adr_o      = REG_WDATA;
        spi_byte_sel_o = 4'b0001;
        spi_we_o       = 1'b1;
        spi_dat_o      = XLEN'(tx_byte);
        state_nx       = S_STAT;
      end
      S_POP: begin
        spi_stb_o      = 1'b1;
        spi_adr_o      = REG_RDATA;
        spi_byte_sel_o = 4'b0001;
        state_nx       = S_STAT;
      end
      S_CS_OFF: begin
        spi_stb_o      = 1'b1;
        spi_adr_o      = REG_CTRL;
        spi_byte_sel_o = 4'hF;
        spi_we_o       = 1'b1;
        spi_dat_o      = XLEN'(ctrl_word(SCK_DIV, CPOL, CPHA, 1'b1, 1'b0));
        state_nx       = S_FIN;
      end
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register in
  // this block sees the pre-edge values of the others, independent of order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      total    <= '0;
      tx_cnt   <= '0;
      rx_cnt   <= '0;
      tmo_cnt  <= '0;
      abort    <= 1'b0;
      rdata_o  <= 8'h00;
      rvalid_o <= 1'b0;
    end else begin
      state    <= state_nx;
      rvalid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_i) begin
            addr_q <= addr_i;
            total  <= {1'b0, len_i} + HDR;
            tx_cnt <= '0;
            rx_cnt <= '0;
            abort  <= 1'b0;
          end
        end
        S_CS_ON: tmo_cnt <= '0;
        S_STAT: begin
          if (tmo_hit)                abort   <= 1'b1;
          else if (state_nx == S_STAT) tmo_cnt <= tmo_cnt + 16'd1;
        end
        S_PUSH: begin
          tx_cnt  <= tx_cnt + CW'(1);
          tmo_cnt <= '0;
        end
        S_POP: begin
          // Opcode and address echo bytes are dropped; only data is streamed.
          if (rx_cnt >= HDR) begin
            rdata_o  <= spi_dat_i[7:0];
            rvalid_o <= 1'b1;
          end
          rx_cnt  <= rx_cnt + CW'(1);
          tmo_cnt <= '0;
        end
        S_FIN:   abort <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_rd_seq.sv
// Bench for spi_flash_rd_seq: a behavioural spi_master + flash model answers the
// register port, and a scoreboard checks streamed bytes, MOSI and completion.
`timescale 1ns/1ps
module tb_spi_flash_rd_seq;
  import spi_flash_rd_seq_pkg::*;

  localparam int XLEN     = 32;
  localparam int LEN_W    = 12;
  localparam int INFLIGHT = 4;
  localparam int TMO      = 100;

  logic             clk = 1'b0;
  logic             rst;
  logic             req;
  logic [23:0]      addr;
  logic [LEN_W-1:0] len;
  logic             busy_o, done_o, err_o, rvalid_o;
  logic [7:0]       rdata_o;
  logic             spi_stb_o, spi_we_o;
  logic [1:0]       spi_adr_o;
  logic [3:0]       spi_byte_sel_o;
  logic [XLEN-1:0]  spi_dat_o, spi_dat_i;

  always #5 clk = ~clk;

  spi_flash_rd_seq #(
    .XLEN(XLEN), .LEN_W(LEN_W), .SCK_DIV(16'd4), .CPOL(1'b0), .CPHA(1'b0),
    .RD_CMD(8'h03), .INFLIGHT(INFLIGHT), .TIMEOUT(16'(TMO))
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .len_i(len),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .rvalid_o(rvalid_o), .spi_stb_o(spi_stb_o), .spi_adr_o(spi_adr_o),
    .spi_byte_sel_o(spi_byte_sel_o), .spi_we_o(spi_we_o), .spi_dat_o(spi_dat_o),
    .spi_dat_i(spi_dat_i)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ a[23:16] ^ 8'h5C;
  endfunction

  // ---------------- spi_master + flash model ----------------
  logic       m_en, m_csn, stuck, shifting, rx_ovf;
  logic [7:0] tx_mem [8];
  logic [7:0] rx_mem [8];
  logic [2:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [3:0] tx_n, rx_n;
  logic [7:0] shift_byte, miso;
  int         shift_left;
  logic [7:0] mosi_log [64];
  int         mosi_n;
  logic       m_active, tx_push, rx_pop, shift_start, shift_done, rx_push;

  assign m_active    = m_en && !m_csn;
  assign tx_push     = spi_stb_o && spi_we_o && (spi_adr_o == REG_WDATA);
  assign rx_pop      = spi_stb_o && !spi_we_o && (spi_adr_o == REG_RDATA) && (rx_n != 0);
  assign shift_start = m_active && !shifting && (tx_n != 0);
  assign shift_done  = m_active && shifting && (shift_left == 0);
  assign rx_push     = shift_done && !stuck && (rx_n != 8);
  assign miso        = (mosi_n < 4) ? 8'hFF
                     : flash_byte({mosi_log[1], mosi_log[2], mosi_log[3]} + 24'(mosi_n - 4));

  always_comb begin
    spi_dat_i = '0;
    if (spi_stb_o && !spi_we_o) begin
      if (spi_adr_o == REG_STATUS) begin
        spi_dat_i[ST_TX_EMPTY] = (tx_n == 0);
        spi_dat_i[ST_TX_FULL]  = (tx_n == 8);
        spi_dat_i[ST_RX_EMPTY] = (rx_n == 0);
        spi_dat_i[ST_RX_FULL]  = (rx_n == 8);
      end else if (spi_adr_o == REG_RDATA) begin
        spi_dat_i[7:0] = rx_mem[rx_rp];
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_en <= 1'b0; m_csn <= 1'b1; shifting <= 1'b0; rx_ovf <= 1'b0;
      tx_wp <= '0; tx_rp <= '0; rx_wp <= '0; rx_rp <= '0; tx_n <= '0; rx_n <= '0;
      shift_left <= 0; mosi_n <= 0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wp] <= spi_dat_o[7:0];
        tx_wp <= tx_wp + 3'd1;
      end
      if (rx_pop) rx_rp <= rx_rp + 3'd1;
      if (shift_start) begin
        shift_byte <= tx_mem[tx_rp];
        tx_rp      <= tx_rp + 3'd1;
        shifting   <= 1'b1;
        shift_left <= int'($urandom_range(1, 6));
      end else if (shift_done) begin
        shifting <= 1'b0;
        if (mosi_n < 64) mosi_log[mosi_n] <= shift_byte;
        mosi_n <= mosi_n + 1;
        if (rx_push) begin
          rx_mem[rx_wp] <= miso;
          rx_wp <= rx_wp + 3'd1;
        end else if (!stuck) rx_ovf <= 1'b1;
      end else if (shifting) shift_left <= shift_left - 1;
      tx_n <= tx_n + 4'(tx_push) - 4'(shift_start);
      rx_n <= rx_n + 4'(rx_push) - 4'(rx_pop);
      if (spi_stb_o && spi_we_o && (spi_adr_o == REG_CTRL)) begin
        m_en  <= spi_dat_o[CTRL_EN_BIT];
        m_csn <= spi_dat_o[CTRL_CSN_BIT];
        if (!(spi_dat_o[CTRL_EN_BIT] && !spi_dat_o[CTRL_CSN_BIT])) shifting <= 1'b0;
        else begin
          mosi_n <= 0;
          tx_wp <= '0; tx_rp <= '0; rx_wp <= '0; rx_rp <= '0; tx_n <= '0; rx_n <= '0;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        err;
    int          len;
    logic [23:0] addr;
  } txn_t;

  txn_t       exp_txn [$];
  logic [7:0] exp_data [$];

  int   mon_stb, mon_push, mon_pop, mon_rv, mon_max_infl, idle_stat, last_idle;
  logic mon_rx_full;

  task automatic clear_mon();
    mon_stb = 0; mon_push = 0; mon_pop = 0; mon_rv = 0; mon_max_infl = 0;
    idle_stat = 0; last_idle = 0; mon_rx_full = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    txn_t       t;
    int         mism;
    logic [7:0] eb;
    if (!rst) begin
      if (spi_stb_o) mon_stb++;
      if (spi_stb_o && !spi_we_o && (spi_adr_o == REG_STATUS)) begin
        idle_stat++;
        if (spi_dat_i[ST_RX_FULL]) mon_rx_full = 1'b1;
      end
      if (spi_stb_o && spi_we_o && (spi_adr_o == REG_CTRL) && spi_dat_o[CTRL_CSN_BIT])
        last_idle = idle_stat;
      if (spi_stb_o && (spi_we_o || spi_adr_o == REG_RDATA)) idle_stat = 0;
      if (tx_push) mon_push++;
      if (spi_stb_o && !spi_we_o && (spi_adr_o == REG_RDATA)) mon_pop++;
      if (mon_push - mon_pop > mon_max_infl) mon_max_infl = mon_push - mon_pop;

      if (rvalid_o) begin
        mon_rv++;
        if (exp_data.size() == 0) check("rvalid_unexpected", 64'd1, 64'd0);
        else check("rdata", 64'(rdata_o), 64'(exp_data.pop_front()));
      end

      if (done_o) begin
        if (exp_txn.size() == 0) check("done_unexpected", 64'd1, 64'd0);
        else begin
          t = exp_txn.pop_front();
          check("err", 64'(err_o), 64'(t.err));
          check("rvalid_count", 64'(mon_rv), t.err ? 64'd0 : 64'(t.len));
          if (t.len == 0) check("len0_bus_strobes", 64'(mon_stb), 64'd0);
          else if (t.err) check("timeout_idle_stat", 64'(last_idle), 64'(TMO));
          else begin
            mism = 0;
            for (int k = 0; k < t.len + 4 && k < 64; k++) begin
              case (k)
                0:       eb = 8'h03;
                1:       eb = t.addr[23:16];
                2:       eb = t.addr[15:8];
                3:       eb = t.addr[7:0];
                default: eb = 8'h00;
              endcase
              if (mosi_log[k] !== eb) mism++;
            end
            check("mosi_count", 64'(mosi_n), 64'(t.len + 4));
            check("mosi_seq_mismatches", 64'(mism), 64'd0);
            check("inflight_le_limit", 64'(mon_max_infl <= INFLIGHT), 64'd1);
            check("rx_full_seen", 64'(mon_rx_full), 64'd0);
            check("rx_overflow", 64'(rx_ovf), 64'd0);
          end
          exp_data.delete();
          clear_mon();
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_txn(input logic [23:0] a, input int l, input logic e);
    txn_t t;
    t.err = e; t.len = l; t.addr = a;
    exp_txn.push_back(t);
    if (!e) for (int i = 0; i < l; i++) exp_data.push_back(flash_byte(a + 24'(i)));
    @(negedge clk);
    req = 1'b1; addr = a; len = LEN_W'(l);
    @(negedge clk);
    req = 1'b0; addr = 24'($urandom); len = LEN_W'($urandom);
    if (l == 0) check("len0_done_latency", 64'(done_o), 64'd1);
    else        check("busy_after_req", 64'(busy_o), 64'd1);
  endtask

  task automatic wait_done(input string name);
    int i;
    i = 0;
    while (!done_o && i < 5000) begin
      req = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      i++;
    end
    req = 1'b0;
    if (!done_o) check({name, "_done_timeout"}, 64'd0, 64'd1);
    repeat (3) @(negedge clk);
    check({name, "_idle_after_done"}, 64'({busy_o, spi_stb_o}), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    clear_mon();
    stuck = 1'b0;
    rst = 1'b1; req = 1'b1; addr = 24'hABCDEF; len = LEN_W'(5);
    repeat (3) @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("reset_outputs",
          64'({busy_o, done_o, err_o, rvalid_o, spi_stb_o, spi_we_o, rdata_o}), 64'd0);
    repeat (3) @(negedge clk);
    check("req_during_reset_ignored", 64'({busy_o, spi_stb_o}), 64'd0);

    start_txn(24'h012345, 3, 1'b0);  wait_done("addr012345_len3");
    start_txn(24'h7FFFFE, 20, 1'b0); wait_done("len20");
    start_txn(24'h000100, 0, 1'b0);  wait_done("len0");

    for (int n = 0; n < 10; n++) begin
      start_txn(24'($urandom), int'($urandom_range(1, 40)), 1'b0);
      wait_done("random");
    end

    stuck = 1'b1;
    start_txn(24'($urandom), 10, 1'b1);
    wait_done("stuck_timeout");
    stuck = 1'b0;

    start_txn(24'h123456, 20, 1'b0);
    i = 0;
    while (mon_push < 6 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    check("reached_byte6", 64'(mon_push >= 6), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset_idle", 64'({busy_o, done_o, rvalid_o, spi_stb_o}), 64'd0);
    rst = 1'b0;
    exp_data.delete();
    exp_txn.delete();
    clear_mon();

    start_txn(24'hC0FFEE, 7, 1'b0);
    wait_done("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
